// File: rtl/arilla_bus_arbiter.sv
// Purpose: two-requester arbiter for one arilla bus segment (hart path = m0, debug SBA = m1).
// Latency: the bus access happens in the ack cycle; read data returns ReadLatency cycles later.
// Backpressure: a requester holds read/write until its ack; a losing requester simply sees ack low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_read/mN_write           request strobes (N = 0,1), held until mN_ack
//   mN_address/byte_enable/wdata  access attributes, muxed onto the bus for the winner
//   mN_lock                    keep ownership after this access (atomic sequences)
//   mN_ack                     request accepted and performed this cycle
//   mN_rvalid/mN_rdata         returned read data for requester N (rdata mirrors bus_rdata)
//   bus_*                      shared bus strobes, address, byte enables, write data, read data
//   busy                       a read is in flight or a lock is held
module arilla_bus_arbiter #(
  parameter int AddressWidth  = 30,
  parameter int DataWidth     = 32,
  parameter int ReadLatency   = 1,
  parameter int FixedPriority = 0,
  parameter int MaxBurst      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m0_read,
  input  logic                     m0_write,
  input  logic [AddressWidth-1:0]  m0_address,
  input  logic [DataWidth/8-1:0]   m0_byte_enable,
  input  logic [DataWidth-1:0]     m0_wdata,
  input  logic                     m0_lock,
  output logic                     m0_ack,
  output logic                     m0_rvalid,
  output logic [DataWidth-1:0]     m0_rdata,
  input  logic                     m1_read,
  input  logic                     m1_write,
  input  logic [AddressWidth-1:0]  m1_address,
  input  logic [DataWidth/8-1:0]   m1_byte_enable,
  input  logic [DataWidth-1:0]     m1_wdata,
  input  logic                     m1_lock,
  output logic                     m1_ack,
  output logic                     m1_rvalid,
  output logic [DataWidth-1:0]     m1_rdata,
  output logic                     bus_read,
  output logic                     bus_write,
  output logic [AddressWidth-1:0]  bus_address,
  output logic [DataWidth/8-1:0]   bus_byte_enable,
  output logic [DataWidth-1:0]     bus_wdata,
  input  logic [DataWidth-1:0]     bus_rdata,
  output logic                     busy
);

  localparam logic [3:0] BurstMax = 4'(MaxBurst);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   rr_ptr_q, rr_ptr_d;   // last winner
  logic [3:0]             burst_q, burst_d;
  logic                   lock_q, lock_d;       // owner's lock from its last grant
  logic [ReadLatency-1:0] tag_vld_q, tag_id_q;

  logic req0, req1;
  logic gnt_vld, gnt_id;
  logic own_id, own_req, peer_req, own_lock, blocked;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign own_id   = (state_q == OWN1);
  assign own_req  = own_id ? req1 : req0;
  assign peer_req = own_id ? req0 : req1;
  assign own_lock = own_id ? m1_lock : m0_lock;
  // A locked owner is never forced to yield.
  assign blocked  = (burst_q == BurstMax) && peer_req && !lock_q;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = 1'b0;
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    lock_d   = lock_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_vld = 1'b1;
          if (req0 && req1) begin
            gnt_id = (FixedPriority != 0) ? 1'b0 : ~rr_ptr_q;
          end else begin
            gnt_id = req1;
          end
        end
      end
      OWN0, OWN1: begin
        if (own_req && !blocked) begin
          gnt_vld = 1'b1;
          gnt_id  = own_id;
        end else if (own_req) begin
          gnt_vld = 1'b1;
          gnt_id  = ~own_id;
        end else if (lock_q && own_lock) begin
          // Owner idles but still asserts lock: hold the bus, grant nobody.
          gnt_vld = 1'b0;
        end else if (peer_req) begin
          // Owner idle with lock low releases immediately to a waiting peer.
          gnt_vld = 1'b1;
          gnt_id  = ~own_id;
        end else begin
          state_d = IDLE;
          lock_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // No grant may leak onto the bus while reset is asserted.
    if (!rst_n) begin
      gnt_vld = 1'b0;
    end

    if (gnt_vld) begin
      state_d  = gnt_id ? OWN1 : OWN0;
      rr_ptr_d = gnt_id;
      lock_d   = gnt_id ? m1_lock : m0_lock;
      if ((state_q != IDLE) && (own_id == gnt_id)) begin
        burst_d = (burst_q >= BurstMax) ? BurstMax : burst_q + 4'd1;
      end else begin
        burst_d = 4'd1;
      end
    end
  end

  assign m0_ack = gnt_vld & ~gnt_id;
  assign m1_ack = gnt_vld &  gnt_id;

  always_comb begin
    bus_read        = 1'b0;
    bus_write       = 1'b0;
    bus_address     = '0;
    bus_byte_enable = '0;
    bus_wdata       = '0;
    if (m0_ack) begin
      bus_read        = m0_read;
      bus_write       = m0_write;
      bus_address     = m0_address;
      bus_byte_enable = m0_byte_enable;
      bus_wdata       = m0_wdata;
    end else if (m1_ack) begin
      bus_read        = m1_read;
      bus_write       = m1_write;
      bus_address     = m1_address;
      bus_byte_enable = m1_byte_enable;
      bus_wdata       = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      burst_q   <= 4'd0;
      lock_q    <= 1'b0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_q      <= burst_d;
      lock_q       <= lock_d;
      // Tag pipeline: stage 0 captures the read granted this cycle.
      tag_vld_q[0] <= gnt_vld & (gnt_id ? m1_read : m0_read);
      tag_id_q[0]  <= gnt_id;
      for (int i = ReadLatency - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

  assign m0_rvalid = tag_vld_q[ReadLatency-1] & ~tag_id_q[ReadLatency-1];
  assign m1_rvalid = tag_vld_q[ReadLatency-1] &  tag_id_q[ReadLatency-1];
  assign m0_rdata  = bus_rdata;
  assign m1_rdata  = bus_rdata;
  assign busy      = (|tag_vld_q) | lock_q;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Bench for arilla_bus_arbiter: three instances with different latency/priority/burst settings
// share one stimulus stream; each has a reference model and a read-return scoreboard.
module tb_arilla_bus_arbiter;

  typedef struct {
    bit          id;
    logic [31:0] dat;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        m0_read, m0_write, m0_lock;
  logic [29:0] m0_address;
  logic [3:0]  m0_byte_enable;
  logic [31:0] m0_wdata;
  logic        m1_read, m1_write, m1_lock;
  logic [29:0] m1_address;
  logic [3:0]  m1_byte_enable;
  logic [31:0] m1_wdata;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave memory contents: address 0x10 holds 0xDEADBEEF.
  function automatic logic [31:0] data_fn(input logic [29:0] a);
    return 32'hDEADBEEF + {a, 2'b00} - 32'h40;
  endfunction

  // Reference grant decision: -1 = none, 0/1 = requester.
  function automatic int pick(input int fp, input int mb, input int st, input bit ptr, input int burst,
                              input bit lk, input bit r0, input bit r1, input bit l0, input bit l1);
    bit r[2];
    bit l[2];
    int own;
    int peer;
    r[0] = r0; r[1] = r1; l[0] = l0; l[1] = l1;
    if (st == 0) begin
      if (r0 && r1) return (fp != 0 || ptr) ? 0 : 1;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    own  = st - 1;
    peer = 1 - own;
    if (r[own]) return (burst == mb && r[peer] && !lk) ? peer : own;
    if (lk && l[own]) return -1;
    return r[peer] ? peer : -1;
  endfunction

  localparam int RL_P [3] = '{1, 3, 2};
  localparam int FP_P [3] = '{0, 0, 1};
  localparam int MB_P [3] = '{1, 4, 15};

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int RL = RL_P[g];
    localparam int FP = FP_P[g];
    localparam int MB = MB_P[g];

    logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_read, bus_write, busy;
    logic [29:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_wdata, bus_rdata;

    arilla_bus_arbiter #(
      .AddressWidth(30), .DataWidth(32), .ReadLatency(RL), .FixedPriority(FP), .MaxBurst(MB)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
      .m0_byte_enable(m0_byte_enable), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
      .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
      .m1_byte_enable(m1_byte_enable), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
      .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
      .bus_byte_enable(bus_byte_enable), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .busy(busy)
    );

    // Fixed-latency slave.
    logic        sl_vld  [RL];
    logic [29:0] sl_addr [RL];
    always @(posedge clk) begin
      sl_vld[0]  <= bus_read;
      sl_addr[0] <= bus_address;
      for (int i = 1; i < RL; i++) begin
        sl_vld[i]  <= sl_vld[i-1];
        sl_addr[i] <= sl_addr[i-1];
      end
    end
    assign bus_rdata = sl_vld[RL-1] ? data_fn(sl_addr[RL-1]) : 32'h0BAD0BAD;

    function automatic string tag(input string s);
      return $sformatf("u%0d.%s", g, s);
    endfunction

    int          st, burst, gnt;
    bit          ptr, lk, busy_e, rv0_e, rv1_e, er, ew;
    logic [29:0] ea;
    logic [3:0]  ebe;
    logic [31:0] ewd, rd_e;
    exp_t        e;
    exp_t        sb[$];

    always @(negedge clk) begin
      if (!rst_n) begin
        st = 0; ptr = 1'b0; burst = 0; lk = 1'b0;
        sb.delete();
        chk(tag("rst_ctl"), {m0_ack, m1_ack, m0_rvalid, m1_rvalid, bus_read, bus_write, busy}, 64'd0);
        chk(tag("rst_addr"), bus_address, 64'd0);
        chk(tag("rst_data"), {bus_byte_enable, bus_wdata}, 64'd0);
      end else begin
        gnt = pick(FP, MB, st, ptr, burst, lk, m0_read | m0_write, m1_read | m1_write, m0_lock, m1_lock);
        busy_e = (sb.size() != 0) || lk;
        er = 1'b0; ew = 1'b0; ea = '0; ebe = '0; ewd = '0;
        if (gnt == 0) begin
          er = m0_read; ew = m0_write; ea = m0_address; ebe = m0_byte_enable; ewd = m0_wdata;
        end else if (gnt == 1) begin
          er = m1_read; ew = m1_write; ea = m1_address; ebe = m1_byte_enable; ewd = m1_wdata;
        end
        rv0_e = 1'b0; rv1_e = 1'b0; rd_e = '0;
        if (sb.size() != 0 && sb[0].due == cyc_n) begin
          e = sb.pop_front();
          rv0_e = !e.id; rv1_e = e.id; rd_e = e.dat;
        end
        chk(tag("ack"), {m0_ack, m1_ack}, {gnt == 0, gnt == 1});
        chk(tag("strobe"), {bus_read, bus_write}, {er, ew});
        chk(tag("addr"), bus_address, ea);
        chk(tag("be_wdata"), {bus_byte_enable, bus_wdata}, {ebe, ewd});
        chk(tag("rvalid"), {m0_rvalid, m1_rvalid}, {rv0_e, rv1_e});
        if (rv0_e) chk(tag("rdata0"), m0_rdata, rd_e);
        if (rv1_e) chk(tag("rdata1"), m1_rdata, rd_e);
        chk(tag("busy"), busy, busy_e);
        if (gnt >= 0 && ((gnt == 1) ? m1_read : m0_read)) begin
          e.id  = (gnt == 1);
          e.dat = data_fn((gnt == 1) ? m1_address : m0_address);
          e.due = cyc_n + RL;
          sb.push_back(e);
        end
        if (gnt >= 0) begin
          burst = (st == gnt + 1) ? ((burst < MB) ? burst + 1 : MB) : 1;
          st    = gnt + 1;
          ptr   = (gnt == 1);
          lk    = (gnt == 1) ? m1_lock : m0_lock;
        end else if (st != 0 && !(lk && ((st == 2) ? m1_lock : m0_lock))) begin
          st = 0;
          lk = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [29:0] a0, input logic l0,
                       input logic r1, input logic w1, input logic [29:0] a1, input logic l1);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_lock = l0;
    m0_byte_enable = a0[3:0] | 4'b0001;
    m0_wdata = {2'b00, a0} ^ 32'hA5A50000;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_lock = l1;
    m1_byte_enable = a1[3:0] | 4'b1000;
    m1_wdata = {2'b00, a1} ^ 32'h5A5A0000;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    repeat (n) to_pos();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cycles=%0d", cyc_n);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Solo read on the RL=1 instance.
    drive(1'b1, 1'b0, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    to_neg();
    chk("solo.ack0", u[0].m0_ack, 64'd1);
    chk("solo.bus_read", u[0].bus_read, 64'd1);
    chk("solo.addr", u[0].bus_address, 64'h10);
    to_pos();
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    to_neg();
    chk("solo.rvalid0", u[0].m0_rvalid, 64'd1);
    chk("solo.rdata", u[0].m0_rdata, 64'hDEADBEEF);
    chk("solo.rvalid1", u[0].m1_rvalid, 64'd0);
    to_pos();
    idle(4);

    // Round-robin contention, MaxBurst=1: last winner was m0, so m1 goes first.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 30'h100, 1'b0, 1'b1, 1'b0, 30'h200, 1'b0);
      to_neg();
      chk("rr.ack0", u[0].m0_ack, (i % 2 == 1));
      chk("rr.ack1", u[0].m1_ack, (i % 2 == 0));
      if (i > 0) chk("rr.rvalid", {u[0].m0_rvalid, u[0].m1_rvalid}, {i % 2 == 0, i % 2 == 1});
      to_pos();
    end
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    to_neg();
    chk("rr.last_rvalid0", u[0].m0_rvalid, 64'd1);
    chk("rr.last_rdata", u[0].m0_rdata, data_fn(30'h100));
    to_pos();
    idle(4);

    // Burst limit on the MaxBurst=4 instance: m1 read raised at cycle 2.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 30'h300, 1'b0, (i >= 2 && i <= 4), 1'b0, 30'h380, 1'b0);
      to_neg();
      chk("burst.ack0", u[1].m0_ack, (i != 4));
      chk("burst.ack1", u[1].m1_ack, (i == 4));
      to_pos();
    end
    idle(4);

    // Lock held by m1 across idle cycles while m0 keeps requesting.
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b1, 30'h400, 1'b1);
    to_neg();
    chk("lock.ack1_first", u[1].m1_ack, 64'd1);
    to_pos();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 30'h500, 1'b0, 1'b0, 1'b0, 30'h400, 1'b1);
      to_neg();
      chk("lock.ack0_held", u[1].m0_ack, 64'd0);
      chk("lock.busy", u[1].busy, 64'd1);
      to_pos();
    end
    drive(1'b0, 1'b1, 30'h500, 1'b0, 1'b0, 1'b1, 30'h401, 1'b0);
    to_neg();
    chk("lock.unlock_ack", {u[1].m0_ack, u[1].m1_ack}, 64'b01);
    to_pos();
    drive(1'b0, 1'b1, 30'h500, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    to_neg();
    chk("lock.ack0_after", u[1].m0_ack, 64'd1);
    chk("lock.busy_clear", u[1].busy, 64'd0);
    to_pos();
    idle(4);

    // Fixed priority with MaxBurst=15: m1 never wins within 6 cycles.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 30'h600, 1'b0, 1'b1, 1'b0, 30'h700, 1'b0);
      to_neg();
      chk("fp.ack", {u[2].m0_ack, u[2].m1_ack}, 64'b10);
      to_pos();
    end
    idle(4);

    // Reset while an m1 read is in flight on the RL=3 instance.
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b1, 1'b0, 30'h20, 1'b0);
    to_neg();
    chk("rst.ack1", u[1].m1_ack, 64'd1);
    to_pos();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 30'h30, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    repeat (2) begin
      to_neg();
      chk("rst.outputs", {u[1].m0_ack, u[1].bus_read, u[1].busy, u[1].m1_rvalid}, 64'd0);
      to_pos();
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("rst.no_rvalid1", u[1].m1_rvalid, 64'd0);
      to_pos();
    end
    drive(1'b1, 1'b0, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    to_neg();
    chk("rst.fresh_ack0", u[1].m0_ack, 64'd1);
    to_pos();
    drive(1'b0, 1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      to_neg();
      chk("rst.fresh_rvalid0", u[1].m0_rvalid, (k == 3));
      if (k == 3) chk("rst.fresh_rdata", u[1].m0_rdata, 64'hDEADBEEF);
      to_pos();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
